sram_row_streamer: RTL and testbench
====================================

# sram_row_streamer

Read-side sequencer placed directly downstream of the 64x64-bit matrix SRAM. On a start command it issues a run of consecutive row reads from a base address and turns the SRAM's fixed one-cycle read latency into a back-pressured valid/ready row stream for the compute array. A 2-entry credit-limited buffer guarantees that no returned row is lost when the consumer stalls.

## Interface
Parameters:
- DATA_W, 64, row width; equals the SRAM word width.
- ADDR_W, 6, SRAM address width; depth is 2^ADDR_W = 64.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  command strobe; sampled only in IDLE.
- base_addr  in  ADDR_W  first row address; sampled with start.
- row_count  in  ADDR_W+1  number of rows, 0..64; sampled with start.
- busy  out  1  high while a command is active.
- done  out  1  one-cycle pulse when a command completes.
- sram_csb  out  1  SRAM chip enable, active-low; low only on read-issue cycles.
- sram_raddr  out  ADDR_W  SRAM read address.
- sram_rdata  in  DATA_W  SRAM registered read data.
- out_valid  out  1  row available.
- out_data  out  DATA_W  row payload.
- out_last  out  1  marks the final row of the command.
- out_ready  in  1  consumer accepts the row.

The block never drives the SRAM write-enable; the write port belongs to the loader.

## Operation
- FSM states are IDLE, ISSUE and DRAIN.
- IDLE, start=1, row_count>0:
  - latch base_addr into rd_ptr and row_count into issue_left and out_left;
  - set busy=1 and go to ISSUE.
- IDLE, start=1, row_count=0:
  - no reads and no output;
  - done pulses in the following cycle; busy stays 0.
- start while busy is ignored.
- ISSUE: a read is issued when issue_left>0 and (fifo_count + inflight − pop) < 2, where pop = out_valid & out_ready. Issuing a read:
  - drives sram_csb=0 and sram_raddr=rd_ptr;
  - increments rd_ptr modulo 64, so base 62 with 4 rows reads 62, 63, 0, 1;
  - decrements issue_left.
- When issue_left reaches 0, go to DRAIN.
- inflight is a register set on each issue cycle. When inflight=1, sram_rdata is pushed into the FIFO at the end of that cycle. Push and pop may occur in the same cycle.
- Handshake: each out_valid & out_ready decrements out_left. out_last = out_valid & (out_left==1).
- DRAIN: when the last row handshakes, go to IDLE. done=1 and busy=0 in the next cycle.
- out_data is held stable while out_valid=1 and out_ready=0.
- Reset values: state=IDLE, busy=0, done=0, sram_csb=1, sram_raddr=0, out_valid=0, out_last=0, out_data=0, inflight=0, FIFO empty.
- Reset in mid-command aborts the command. Returning in-flight data is discarded because inflight is cleared.

## Timing
- Start is sampled at edge E0.
- First read is issued in the cycle after E0.
- Data is pushed at E2; out_valid=1 in the cycle after E2, i.e. 3 cycles of start-to-first-row latency.
- With out_ready held high, throughput is one row per cycle and sram_csb stays low for row_count consecutive cycles.
- Under stall, at most 2 rows are outstanding (buffered plus in flight). Reads resume in the cycle after the pop that frees a credit.
- done is asserted exactly one cycle after the out_last handshake.
- A new start is accepted in the cycle done is high, since state is IDLE.

## Structure
- Shared package `mat_pkg` holds:
  - DATA_W and ADDR_W constants;
  - the FSM state enum (IDLE/ISSUE/DRAIN);
  - SRAM_DEPTH=64.
- Sub-module `sram_rd_fifo2`: a 2-entry FIFO with push, pop, count, head data and a registered head.
- Top level contains the FSM, counters and credit logic.

## Test plan
- Preload mem[i]=i×0x0101010101010101. start, base 0, count 4, out_ready=1:
  - rows 0..3 appear on consecutive cycles starting 3 cycles after start;
  - out_last is set on row 3;
  - done pulses 1 cycle later.
- Wrap-around: base 62, count 4 → data from addresses 62, 63, 0, 1 in order.
- Back-pressure: count 8 with out_ready toggled randomly:
  - all 8 rows are delivered in order with no loss or duplication;
  - out_data is stable during stalls;
  - FIFO occupancy never exceeds 2.
- count 0 → no sram_csb low cycle, done pulses 1 cycle after start, busy stays 0. count 64 from base 5 → 64 rows, ending at address 4.
- Reset asserted mid-stream of a 16-row command, with out_ready=0 and two rows outstanding:
  - all outputs return to reset values the next cycle;
  - a new start then delivers correct data with no stale rows.
- start pulsed during busy is ignored and the current command completes unchanged. start coincident with done begins the new command immediately.

Source files
------------

// File: rtl/mat_pkg.sv
// Shared constants and FSM state type for the matrix SRAM read path.
package mat_pkg;

  localparam int DATA_W     = 64;
  localparam int ADDR_W     = 6;
  localparam int SRAM_DEPTH = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/sram_rd_fifo2.sv
// Two-entry row buffer; the head entry is a register so o_head holds steady while stalled.
module sram_rd_fifo2 #(
  parameter int DATA_W = mat_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic              o_valid,
  output logic [1:0]        o_count,
  output logic [DATA_W-1:0] o_head
);

  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_tail;
  logic [1:0]        r_count;
  logic              w_pop;
  logic              w_push;

  // A pop on an empty buffer or a push into a full one without a pop is dropped.
  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= i_data;
          else                 r_tail <= i_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          if (r_count == 2'd2) r_head <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd2) begin
            r_head <= r_tail;
            r_tail <= i_data;
          end else begin
            r_head <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;
  assign o_head  = r_head;

endmodule

// File: rtl/sram_row_streamer.sv
// Issues consecutive SRAM row reads and returns them as a credit-limited valid/ready stream.
module sram_row_streamer #(
  parameter int DATA_W = mat_pkg::DATA_W,
  parameter int ADDR_W = mat_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   row_count,
  output logic              busy,
  output logic              done,
  output logic              sram_csb,
  output logic [ADDR_W-1:0] sram_raddr,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready
);

  import mat_pkg::*;

  state_t            r_state;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_issue_left;
  logic [ADDR_W:0]   r_out_left;
  logic              r_inflight;
  logic              r_busy;
  logic              r_done;

  logic              w_valid;
  logic [1:0]        w_count;
  logic              w_pop;
  logic              w_issue;
  logic [2:0]        w_occ;

  sram_rd_fifo2 #(.DATA_W(DATA_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_data  (sram_rdata),
    .i_pop   (w_pop),
    .o_valid (w_valid),
    .o_count (w_count),
    .o_head  (out_data)
  );

  // Buffered plus in-flight rows, less a same-cycle pop, must stay below two to issue.
  assign w_pop   = w_valid && out_ready;
  assign w_occ   = {1'b0, w_count} + {2'b00, r_inflight};
  assign w_issue = (r_state == ISSUE) && (r_issue_left != '0) &&
                   (w_occ < (3'd2 + {2'b00, w_pop}));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_rd_ptr     <= '0;
      r_issue_left <= '0;
      r_out_left   <= '0;
      r_inflight   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_rd_ptr     <= r_rd_ptr + 1'b1;
        r_issue_left <= r_issue_left - 1'b1;
      end
      if (w_pop) r_out_left <= r_out_left - 1'b1;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (row_count != '0) begin
              r_rd_ptr     <= base_addr;
              r_issue_left <= row_count;
              r_out_left   <= row_count;
              r_busy       <= 1'b1;
              r_state      <= ISSUE;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (w_issue && (r_issue_left == 1)) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_pop && (r_out_left == 1)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign sram_csb   = ~w_issue;
  assign sram_raddr = r_rd_ptr;
  assign out_valid  = w_valid;
  assign out_last   = w_valid && (r_out_left == 1);

endmodule

// File: tb/tb_sram_row_streamer.sv
// Scoreboard bench: commands push expected rows, a negedge monitor pops and compares them.
module tb_sram_row_streamer;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  base_addr = '0;
  logic [6:0]  row_count = '0;
  logic        busy;
  logic        done;
  logic        sram_csb;
  logic [5:0]  sram_raddr;
  logic [63:0] sram_rdata = '0;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_last;
  logic        out_ready = 1'b0;

  logic [63:0] mem [64];
  exp_t        expQ [$];
  int          errors = 0;
  int          checks = 0;
  int          readyMode = 0;
  int          issued = 0;
  int          popped = 0;
  logic [5:0]  lastAddr = '0;
  logic        expectDone = 1'b0;
  logic        prevStall = 1'b0;
  logic [63:0] prevData = '0;

  sram_row_streamer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .row_count  (row_count),
    .busy       (busy),
    .done       (done),
    .sram_csb   (sram_csb),
    .sram_raddr (sram_raddr),
    .sram_rdata (sram_rdata),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 64'(i) * 64'h0101010101010101;
  end

  // SRAM model with a one-cycle registered read.
  always @(posedge clk) begin
    if (!sram_csb) sram_rdata <= mem[sram_raddr];
  end

  always @(posedge clk) begin
    #2;
    if (readyMode == 2) out_ready = 1'($urandom_range(0, 1));
    else                out_ready = (readyMode == 1);
  end

  function automatic logic [63:0] rowVal(input int addr);
    return 64'(addr % 64) * 64'h0101010101010101;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int base, input int count);
    for (int i = 0; i < count; i++) begin
      exp_t e;
      e.data = rowVal(base + i);
      e.last = (i == count - 1);
      expQ.push_back(e);
    end
    start     = 1'b1;
    base_addr = 6'(base);
    row_count = 7'(count);
    tick();
    start     = 1'b0;
  endtask

  task automatic waitDone(input int limit, input string name);
    int n = 0;
    while (!done && n < limit) begin
      tick();
      n++;
    end
    checkOutput({name, "_done_seen"}, 64'(done), 64'd1);
    checkOutput({name, "_queue_empty"}, 64'(expQ.size()), 64'd0);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_csb"}, 64'(sram_csb), 64'd1);
    checkOutput({tag, "_raddr"}, 64'(sram_raddr), 64'd0);
    checkOutput({tag, "_valid"}, 64'(out_valid), 64'd0);
    checkOutput({tag, "_last"}, 64'(out_last), 64'd0);
    checkOutput({tag, "_data"}, out_data, 64'd0);
  endtask

  // Monitor: scoreboard pops, stall stability, outstanding-row bound, done after last.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        expectDone = 1'b0;
        prevStall  = 1'b0;
        issued     = 0;
        popped     = 0;
      end else begin
        if (expectDone) begin
          checkOutput("done_after_last", 64'(done), 64'd1);
          expectDone = 1'b0;
        end
        if (prevStall && out_valid) checkOutput("stall_stable", out_data, prevData);
        if (!sram_csb) begin
          issued++;
          lastAddr = sram_raddr;
        end
        if (out_valid && out_ready) begin
          popped++;
          if (expQ.size() == 0) begin
            checkOutput("unexpected_row", 64'(expQ.size()), 64'd1);
          end else begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("row_data", out_data, e.data);
            checkOutput("row_last", 64'(out_last), 64'(e.last));
            if (e.last) expectDone = 1'b1;
          end
        end
        if (busy) checkOutput("outstanding_le2", 64'((issued - popped) <= 2), 64'd1);
        prevStall = out_valid && !out_ready;
        prevData  = out_data;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int issuedBefore;
    rst = 1'b1;
    tick();
    tick();
    checkReset("reset");
    rst = 1'b0;
    tick();

    // Basic run: latency, consecutive rows, last and done timing.
    readyMode = 1;
    applyStimulus(0, 4);
    checkOutput("t1_csb_first", 64'(sram_csb), 64'd0);
    checkOutput("t1_addr_first", 64'(sram_raddr), 64'd0);
    checkOutput("t1_busy", 64'(busy), 64'd1);
    tick();
    checkOutput("t1_not_valid_yet", 64'(out_valid), 64'd0);
    tick();
    checkOutput("t1_first_valid", 64'(out_valid), 64'd1);
    checkOutput("t1_first_data", out_data, rowVal(0));
    tick();
    checkOutput("t1_csb_third", 64'(sram_csb), 64'd0);
    checkOutput("t1_addr_fourth", 64'(sram_raddr), 64'd3);
    tick();
    checkOutput("t1_csb_idle", 64'(sram_csb), 64'd1);
    tick();
    checkOutput("t1_last", 64'(out_last), 64'd1);
    tick();
    checkOutput("t1_done", 64'(done), 64'd1);
    checkOutput("t1_busy_low", 64'(busy), 64'd0);
    checkOutput("t1_valid_low", 64'(out_valid), 64'd0);
    tick();
    checkOutput("t1_done_pulse", 64'(done), 64'd0);

    // Address wrap-around.
    applyStimulus(62, 4);
    waitDone(40, "wrap");
    tick();

    // Random back-pressure.
    readyMode = 2;
    applyStimulus(10, 8);
    waitDone(300, "bp");
    readyMode = 1;
    tick();

    // Zero-length command.
    issuedBefore = issued;
    applyStimulus(0, 0);
    checkOutput("t0_done", 64'(done), 64'd1);
    checkOutput("t0_busy", 64'(busy), 64'd0);
    tick();
    checkOutput("t0_done_pulse", 64'(done), 64'd0);
    tick();
    tick();
    checkOutput("t0_no_read", 64'(issued - issuedBefore), 64'd0);

    // Full-depth command wrapping from base 5.
    issuedBefore = issued;
    applyStimulus(5, 64);
    waitDone(200, "full");
    checkOutput("full_reads", 64'(issued - issuedBefore), 64'd64);
    checkOutput("full_last_addr", 64'(lastAddr), 64'd4);
    tick();

    // Start while busy is ignored.
    applyStimulus(20, 6);
    tick();
    start     = 1'b1;
    base_addr = 6'd40;
    row_count = 7'd3;
    tick();
    start = 1'b0;
    waitDone(60, "ignore");
    tick();
    tick();
    tick();
    checkOutput("ignore_idle", 64'(busy), 64'd0);

    // Start coincident with done.
    applyStimulus(0, 2);
    waitDone(40, "coinc_a");
    applyStimulus(30, 3);
    checkOutput("coinc_busy", 64'(busy), 64'd1);
    checkOutput("coinc_csb", 64'(sram_csb), 64'd0);
    checkOutput("coinc_addr", 64'(sram_raddr), 64'd30);
    waitDone(40, "coinc_b");
    tick();

    // Reset mid-stream with two rows outstanding.
    readyMode = 0;
    applyStimulus(8, 16);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("rst_outstanding", 64'(issued - popped), 64'd2);
    checkOutput("rst_held_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    expQ.delete();
    tick();
    checkReset("midrst");
    rst = 1'b0;
    readyMode = 1;
    tick();
    tick();
    checkOutput("post_rst_no_valid", 64'(out_valid), 64'd0);
    applyStimulus(0, 3);
    waitDone(40, "post_rst");
    tick();
    tick();

    checkOutput("final_queue_empty", 64'(expQ.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
